// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA text renderer and the tile screen buffer.
// Holds 640x480@60 timing, tile geometry, address/data widths and the pixel-pipeline meta struct.
// No logic; imported by vga_text_renderer and vga_font_rom.
package vga_pkg;

    // 640x480@60 timing, 25 MHz pixel clock
    localparam int H_VISIBLE    = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;   // 800
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;                     // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;                   // 752, exclusive

    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;   // 525
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;                     // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;                   // 492, exclusive

    // Tile geometry
    localparam int TILE_W  = 8;
    localparam int TILE_H  = 16;
    localparam int TILES_X = H_VISIBLE / TILE_W;   // 80
    localparam int TILES_Y = V_VISIBLE / TILE_H;   // 30

    // Widths shared with the screen buffer
    localparam int ADDR_COL_WIDTH  = 7;
    localparam int ADDR_ROW_WIDTH  = 5;
    localparam int DATA_WIDTH      = 7;
    localparam int COLOR_WIDTH     = 12;
    localparam int FONT_ADDR_WIDTH = DATA_WIDTH + 4;   // {char, glyph row}
    localparam int CNT_WIDTH       = 10;

    // Per-pixel side information carried alongside the char/glyph fetch
    typedef struct packed {
        logic [2:0] xbit;
        logic [3:0] yrow;
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       frame_start;
        logic       cursor;
    } pix_meta_t;

endpackage

// File: rtl/vga_font_rom.sv
// 2048x8 font ROM, address = {char code, glyph row}; MSB of data is the leftmost pixel.
// Latency: 1 cycle (registered read). No backpressure: reads every cycle.
// Ports: clk, rst (sync, active-high, clears data), addr, data. Built-in table: 0x41 'A',
// 0x7F solid block; every other code (including 0) is blank.
module vga_font_rom
    import vga_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FONT_ADDR_WIDTH-1:0] addr,
    output logic [7:0]                 data
);

    // Glyph 'A', row 0 in the top byte
    localparam logic [127:0] GLYPH_A = 128'h0000_0018_3C66_667E_6666_6666_0000_0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else begin
            case (addr[FONT_ADDR_WIDTH-1:4])
                7'h41:   data <= GLYPH_A[{~addr[3:0], 3'b000} +: 8];
                7'h7F:   data <= 8'hFF;
                default: data <= 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/vga_text_renderer.sv
// VGA text renderer: 640x480@60 timing, tile address out, char in, font lookup, RGB + syncs out.
// Latency: 3 cycles counter->rgb_o (syncs/frame_start delayed equally); addresses 1 cycle.
// No backpressure: free-running; char_i is sampled on the edge after col_r_o/row_r_o are shown.
// Ports: clk_i, rst_i (sync, active-high), col_r_o/row_r_o (buffer read address), char_i,
// fg_color_i/bg_color_i, rgb_o, hsync_o/vsync_o (active-low), frame_start_o (pixel (0,0)).
// Optional macro VGA_CURSOR_EN adds cursor_col_i/cursor_row_i/cursor_en_i: blinking underline.
module vga_text_renderer #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    output logic [vga_pkg::ADDR_COL_WIDTH-1:0] col_r_o,
    output logic [vga_pkg::ADDR_ROW_WIDTH-1:0] row_r_o,
    input  logic [vga_pkg::DATA_WIDTH-1:0]     char_i,
    input  logic [vga_pkg::COLOR_WIDTH-1:0]    fg_color_i,
    input  logic [vga_pkg::COLOR_WIDTH-1:0]    bg_color_i,
`ifdef VGA_CURSOR_EN
    input  logic [vga_pkg::ADDR_COL_WIDTH-1:0] cursor_col_i,
    input  logic [vga_pkg::ADDR_ROW_WIDTH-1:0] cursor_row_i,
    input  logic                               cursor_en_i,
`endif
    output logic [vga_pkg::COLOR_WIDTH-1:0]    rgb_o,
    output logic                               hsync_o,
    output logic                               vsync_o,
    output logic                               frame_start_o
);
    import vga_pkg::*;

    localparam int HT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HSS = H_VISIBLE + H_FRONT;
    localparam int HSE = HSS + H_SYNC;
    localparam int VSS = V_VISIBLE + V_FRONT;
    localparam int VSE = VSS + V_SYNC;

    localparam pix_meta_t META_RST = '{xbit: 3'd0, yrow: 4'd0, active: 1'b0, hsync: 1'b1,
                                       vsync: 1'b1, frame_start: 1'b0, cursor: 1'b0};

    logic [CNT_WIDTH-1:0]      hcount, vcount;
    logic                      active0, cursor0;
    logic [ADDR_COL_WIDTH-1:0] tile_col;
    logic [ADDR_ROW_WIDTH-1:0] tile_row;
    pix_meta_t                 s0, s1, s2;
    logic [7:0]                glyph, glyph_eff;
    logic                      pixel;

    // Stage 0: raster counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == CNT_WIDTH'(HT - 1)) begin
            hcount <= '0;
            vcount <= (vcount == CNT_WIDTH'(VT - 1)) ? '0 : vcount + 1'b1;
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    assign active0  = (hcount < CNT_WIDTH'(H_VISIBLE)) && (vcount < CNT_WIDTH'(V_VISIBLE));
    assign tile_col = hcount[3 +: ADDR_COL_WIDTH];
    assign tile_row = vcount[4 +: ADDR_ROW_WIDTH];

`ifdef VGA_CURSOR_EN
    logic [4:0] frame_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i)              frame_cnt <= '0;
        else if (frame_start_o) frame_cnt <= frame_cnt + 1'b1;
    end

    // Upper bit of the frame counter gives the 32-frame blink (16 on, 16 off)
    assign cursor0 = cursor_en_i && frame_cnt[4] && active0 &&
                     (tile_col == cursor_col_i) && (tile_row == cursor_row_i);
`else
    assign cursor0 = 1'b0;
`endif

    always_comb begin
        s0             = META_RST;
        s0.xbit        = hcount[2:0];
        s0.yrow        = vcount[3:0];
        s0.active      = active0;
        s0.hsync       = !((hcount >= CNT_WIDTH'(HSS)) && (hcount < CNT_WIDTH'(HSE)));
        s0.vsync       = !((vcount >= CNT_WIDTH'(VSS)) && (vcount < CNT_WIDTH'(VSE)));
        s0.frame_start = (hcount == '0) && (vcount == '0);
        s0.cursor      = cursor0;
    end

    // Stage 1: registered buffer address; blanking addresses park at tile (0,0)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_r_o <= '0;
            row_r_o <= '0;
            s1      <= META_RST;
            s2      <= META_RST;
        end else begin
            col_r_o <= active0 ? tile_col : '0;
            row_r_o <= active0 ? tile_row : '0;
            s1      <= s0;
            s2      <= s1;
        end
    end

    // Stage 2: font lookup of the char returned for the stage-1 address
    vga_font_rom u_font_rom (
        .clk  (clk_i),
        .rst  (rst_i),
        .addr ({char_i, s1.yrow}),
        .data (glyph)
    );

    // Stage 3: underline rows 14/15 on the cursor tile, then pick the pixel bit
    always_comb begin
        glyph_eff = glyph;
        if (s2.cursor && (s2.yrow >= 4'd14)) glyph_eff = 8'hFF;
        pixel = glyph_eff[3'd7 - s2.xbit];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_o         <= '0;
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
            frame_start_o <= 1'b0;
        end else begin
            rgb_o         <= s2.active ? (pixel ? fg_color_i : bg_color_i) : '0;
            hsync_o       <= s2.hsync;
            vsync_o       <= s2.vsync;
            frame_start_o <= s2.frame_start;
        end
    end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Scoreboard bench for vga_text_renderer: full horizontal timing, shortened vertical
// timing (40 lines per frame) so two frames and a mid-frame reset fit in a short run.
module tb_vga_text_renderer;

    localparam int VV    = 32;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 4;
    localparam int VT    = VV + VF + VS + VB;
    localparam int FRAME = 800 * VT;

    typedef struct packed {
        logic [6:0]  col;
        logic [4:0]  row;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    typedef struct {
        int    ep;
        int    kk;
        int    sel;   // 0 col, 1 row, 2 rgb, 3 hsync, 4 vsync, 5 frame_start
        int    val;
        string name;
    } dir_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  col_r;
    logic [4:0]  row_r;
    logic [6:0]  char_d;
    logic [11:0] fg = 12'hFFF;
    logic [11:0] bg = 12'h000;
    logic [11:0] rgb;
    logic        hs, vs, fs;
`ifdef VGA_CURSOR_EN
    logic [6:0]  cur_col = 7'd5;
    logic [4:0]  cur_row = 5'd2;
    logic        cur_en  = 1'b0;
`endif

    exp_t q[$];
    dir_t dq[$];
    int   total = 0;
    int   bad   = 0;
    int   k     = 0;
    int   epoch = 0;
    bit   done  = 1'b0;

    logic [7:0] glyph_a [16] = '{8'h00, 8'h00, 8'h00, 8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E,
                                 8'h66, 8'h66, 8'h66, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00};

    vga_text_renderer #(
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .col_r_o      (col_r),
        .row_r_o      (row_r),
        .char_i       (char_d),
        .fg_color_i   (fg),
        .bg_color_i   (bg),
`ifdef VGA_CURSOR_EN
        .cursor_col_i (cur_col),
        .cursor_row_i (cur_row),
        .cursor_en_i  (cur_en),
`endif
        .rgb_o        (rgb),
        .hsync_o      (hs),
        .vsync_o      (vs),
        .frame_start_o(fs)
    );

    always #20 clk = ~clk;

    // Screen buffer contents
    function automatic logic [6:0] tb_char(logic [6:0] c, logic [4:0] r);
        if (c == 7'd0  && r == 5'd0) return 7'h41;
        if (c == 7'd1  && r == 5'd0) return 7'h7F;
        if (c == 7'd79 && r == 5'd0) return 7'h7F;
        if (c == 7'd79 && r == 5'd1) return 7'h41;
        if (c == 7'd3  && r == 5'd1) return 7'h41;
        return 7'h00;
    endfunction

    function automatic logic [7:0] tb_glyph(logic [6:0] c, int r);
        if (c == 7'h41) return glyph_a[r];
        if (c == 7'h7F) return 8'hFF;
        return 8'h00;
    endfunction

    always_comb char_d = tb_char(col_r, row_r);

    // Expected outputs during the cycle that is kk cycles after the last reset edge
    function automatic exp_t model(int kk);
        exp_t       e;
        int         p, h, v;
        logic [7:0] g;
        e = '{col: 7'd0, row: 5'd0, rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
        if (kk >= 1) begin
            p = kk - 1; h = p % 800; v = (p / 800) % VT;
            if (h < 640 && v < VV) begin
                e.col = 7'(h / 8);
                e.row = 5'(v / 16);
            end
        end
        if (kk >= 3) begin
            p = kk - 3; h = p % 800; v = (p / 800) % VT;
            e.hs = !(h >= 656 && h < 752);
            e.vs = !(v >= VV + VF && v < VV + VF + VS);
            e.fs = (p % FRAME == 0);
            if (h < 640 && v < VV) begin
                g = tb_glyph(tb_char(7'(h / 8), 5'(v / 16)), v % 16);
                e.rgb = g[7 - (h % 8)] ? fg : bg;
            end
        end
        return e;
    endfunction

    function automatic int sig(int sel);
        case (sel)
            0:       return int'(col_r);
            1:       return int'(row_r);
            2:       return int'(rgb);
            3:       return int'(hs);
            4:       return int'(vs);
            default: return int'(fs);
        endcase
    endfunction

    task automatic add(int ep, int kk, int sel, int val, string name);
        dir_t d;
        d.ep = ep; d.kk = kk; d.sel = sel; d.val = val; d.name = name;
        dq.push_back(d);
    endtask

    // Producer: on each clock edge, push what the DUT must show for the following cycle
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                if (k > 10) epoch++;
                k = 0;
            end else begin
                k++;
            end
            q.push_back(model(k));
        end
    end

    // Monitor: compare on the falling edge, away from the active edge
    initial begin
        exp_t e, got;
        dir_t d;
        forever begin
            @(negedge clk);
            if (done) break;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL no_expected ep=%0d k=%0d", epoch, k);
            end else begin
                e   = q.pop_front();
                got = '{col: col_r, row: row_r, rgb: rgb, hs: hs, vs: vs, fs: fs};
                if (got !== e) begin
                    bad++;
                    $display("FAIL stream ep=%0d k=%0d got col=%0d row=%0d rgb=%h hs=%b vs=%b fs=%b want col=%0d row=%0d rgb=%h hs=%b vs=%b fs=%b",
                             epoch, k, got.col, got.row, got.rgb, got.hs, got.vs, got.fs,
                             e.col, e.row, e.rgb, e.hs, e.vs, e.fs);
                end
            end
            while (dq.size() > 0 && dq[0].ep == epoch && dq[0].kk == k) begin
                d = dq.pop_front();
                total++;
                if (sig(d.sel) != d.val) begin
                    bad++;
                    $display("FAIL %s ep=%0d k=%0d got=%0h want=%0h", d.name, epoch, k, sig(d.sel), d.val);
                end
            end
        end
    end

    initial begin
        int line4_a [8] = '{'h000, 'h000, 'hFFF, 'hFFF, 'hFFF, 'hFFF, 'h000, 'h000};
        int line4_b [8] = '{'h00A, 'h00A, 'h0F0, 'h0F0, 'h0F0, 'h0F0, 'h00A, 'h00A};

        // Hand-computed checkpoints, in (epoch, cycle) order
        add(0, 0, 3, 1, "rst_hsync");   add(0, 0, 4, 1, "rst_vsync");
        add(0, 0, 2, 0, "rst_rgb");     add(0, 0, 5, 0, "rst_fs");
        add(0, 0, 0, 0, "rst_col");     add(0, 0, 1, 0, "rst_row");
        add(0, 2, 5, 0, "fs_early");    add(0, 3, 5, 1, "fs_first");
        add(0, 4, 5, 0, "fs_one_cycle");
        add(0, 640, 0, 79, "col_last"); add(0, 641, 0, 0, "col_blank");
        add(0, 642, 2, 'hFFF, "rgb_x639"); add(0, 643, 2, 0, "rgb_x640");
        add(0, 658, 3, 1, "hs_before"); add(0, 659, 3, 0, "hs_fall");
        add(0, 754, 3, 0, "hs_last");   add(0, 755, 3, 1, "hs_rise");
        for (int x = 0; x < 8; x++) add(0, 3203 + x, 2, line4_a[x], "line4_fgbg");
        add(0, 13433, 0, 79, "last_col");  add(0, 13433, 1, 1, "last_row");
        add(0, 13441, 0, 0, "col_hblank"); add(0, 13441, 1, 0, "row_hblank");
        add(0, 27202, 4, 1, "vs_before");  add(0, 27203, 4, 0, "vs_fall");
        add(0, 28803, 4, 1, "vs_rise");
        add(0, FRAME + 2, 5, 0, "fs_frame_early");
        add(0, FRAME + 3, 5, 1, "fs_period");
        add(0, FRAME + 3, 2, 'h00A, "rgb_bg_new");
        add(0, FRAME + 11, 2, 'h0F0, "rgb_fg_new");
        add(0, 48300, 2, 'h00A, "rgb_pre_reset");
        add(1, 0, 3, 1, "mid_rst_hsync"); add(1, 0, 4, 1, "mid_rst_vsync");
        add(1, 0, 2, 0, "mid_rst_rgb");   add(1, 0, 0, 0, "mid_rst_col");
        add(1, 2, 5, 0, "mid_fs_early");  add(1, 3, 5, 1, "mid_fs_restart");
        for (int x = 0; x < 8; x++) add(1, 3203 + x, 2, line4_b[x], "line4_new_colour");

        repeat (4) @(negedge clk);
        rst = 1'b0;

        // Change colours during vertical blanking of the first frame
        for (int i = 0; i < 60000 && !(epoch == 0 && k >= 28000); i++) @(negedge clk);
        fg = 12'h0F0;
        bg = 12'h00A;

        // One-cycle reset with the raster at hcount=300, vcount=20 of the second frame
        for (int i = 0; i < 30000 && !(epoch == 0 && k >= 48300); i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10000 && !(epoch == 1 && k >= 4000); i++) @(negedge clk);
        if (epoch != 1) begin
            total++;
            bad++;
            $display("FAIL run_budget epoch=%0d k=%0d want epoch=1", epoch, k);
        end
        done = 1'b1;
        @(negedge clk);
        #1;
        while (dq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s not_reached ep=%0d k=%0d", dq[0].name, dq[0].ep, dq[0].kk);
            void'(dq.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
